// File: rtl/fifo_wr_arbiter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wr_arbiter_ctrl: round-robin N-writer arbiter and FIFO pointer |
// | controller for a single shared memory.  Revision: 1.0               |
// +--------------------------------------------------------------------+
module fifo_wr_arbiter_ctrl #(
   parameter int WIDTH     = 8,
   parameter int PTR_WIDTH = 5,
   parameter int NREQ      = 4,
   parameter int AF_THRESH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   input  logic                     flush,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic                     mem_write,
   output logic [PTR_WIDTH-1:0]     mem_write_ptr,
   output logic [PTR_WIDTH-1:0]     mem_read_ptr,
   output logic [WIDTH-1:0]         mem_data_write,
   output logic                     mem_full,
   output logic                     mem_empty,
   output logic [PTR_WIDTH-1:0]     count,
   output logic                     almost_full,
   output logic                     underflow_err
);

   localparam int IDW = $clog2(NREQ);

   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [IDW-1:0]       rr_ptr;
   logic [IDW-1:0]       grant_id_q;
   logic                 full;
   logic                 empty;
   logic                 grant_hit;
   logic [IDW-1:0]       grant_idx;
   logic [IDW:0]         cand;
   logic                 do_write;
   logic                 do_read;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
                  (wr_ptr[PTR_WIDTH-2:0] == rd_ptr[PTR_WIDTH-2:0]);

   // Scan from the priority pointer upward, wrapping modulo NREQ (which need not be a power of two).
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!grant_hit && req_valid[cand[IDW-1:0]]) begin
            grant_hit = 1'b1;
            grant_idx = cand[IDW-1:0];
         end
      end
   end

   // rst_n gates the strobe so nothing reaches memory while reset is held.
   assign do_write = rst_n & grant_hit & ~full & ~flush;
   assign do_read  = rd_en & ~empty & ~flush;

   always_comb begin
      req_ready = '0;
      if (do_write) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign mem_data_write = do_write ? req_data[int'(grant_idx)*WIDTH +: WIDTH] : '0;
   assign mem_write      = do_write;
   assign mem_write_ptr  = wr_ptr;
   assign mem_read_ptr   = rd_ptr;
   assign mem_full       = full;
   assign mem_empty      = empty;
   assign rd_valid       = ~empty;
   assign count          = wr_ptr - rd_ptr;
   assign almost_full    = (count >= PTR_WIDTH'(AF_THRESH));
   assign grant_id       = grant_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         rr_ptr        <= '0;
         grant_id_q    <= '0;
         underflow_err <= 1'b0;
      end else begin
         if (flush) begin
            rd_ptr <= wr_ptr;
         end else if (do_read) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         if (do_write) begin
            wr_ptr     <= wr_ptr + PTR_WIDTH'(1);
            rr_ptr     <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            grant_id_q <= grant_idx;
         end
         if (rd_en && empty) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
`default_nettype none
// Directed bench for fifo_wr_arbiter_ctrl: vector table plus corner-case sequences.
module tb_fifo_wr_arbiter_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [1:0]  grant_id;
   logic        flush = 1'b0;
   logic        rd_en = 1'b0;
   logic        rd_valid;
   logic        mem_write;
   logic [4:0]  mem_write_ptr;
   logic [4:0]  mem_read_ptr;
   logic [7:0]  mem_data_write;
   logic        mem_full;
   logic        mem_empty;
   logic [4:0]  count;
   logic        almost_full;
   logic        underflow_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [16];
   logic [7:0] rdata;

   always #5 clk = ~clk;

   fifo_wr_arbiter_ctrl #(.WIDTH(8), .PTR_WIDTH(5), .NREQ(4), .AF_THRESH(12)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .grant_id(grant_id), .flush(flush), .rd_en(rd_en),
      .rd_valid(rd_valid), .mem_write(mem_write), .mem_write_ptr(mem_write_ptr),
      .mem_read_ptr(mem_read_ptr), .mem_data_write(mem_data_write),
      .mem_full(mem_full), .mem_empty(mem_empty), .count(count),
      .almost_full(almost_full), .underflow_err(underflow_err)
   );

   // Memory the controller sits in front of.
   always @(posedge clk) begin
      if (mem_write && !mem_full) mem[mem_write_ptr[3:0]] <= mem_data_write;
   end
   assign rdata = mem[mem_read_ptr[3:0]];

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        rd;
      logic [3:0]  ready;
      logic [4:0]  cnt;
      logic [4:0]  wptr;
      logic [1:0]  gid;
      logic        rv;
      logic [7:0]  rd_data;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic rd,
                               logic [3:0] rdy, logic [4:0] c, logic [4:0] wp,
                               logic [1:0] g, logic rv, logic [7:0] rdat);
      vec_t t;
      t.rst = r; t.valid = v; t.data = d; t.rd = rd; t.ready = rdy; t.cnt = c;
      t.wptr = wp; t.gid = g; t.rv = rv; t.rd_data = rdat;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; rd_en = 1'b0; flush = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_d;
      logic [7:0] q [$];
      logic [4:0] wp;
      logic [4:0] rp;

      tbl[0]  = mk(0, 4'b0001, 32'h0000_00A1, 0, 4'b0001, 0, 0, 0, 0, 8'h00);
      tbl[1]  = mk(0, 4'b0001, 32'h0000_00A2, 0, 4'b0001, 1, 1, 0, 1, 8'hA1);
      tbl[2]  = mk(0, 4'b0000, 32'h0,         1, 4'b0000, 2, 2, 0, 1, 8'hA1);
      tbl[3]  = mk(0, 4'b0000, 32'h0,         1, 4'b0000, 1, 2, 0, 1, 8'hA2);
      tbl[4]  = mk(0, 4'b0000, 32'h0,         0, 4'b0000, 0, 2, 0, 0, 8'h00);
      tbl[5]  = mk(1, 4'b1111, 32'h44332211,  0, 4'b0000, 0, 0, 0, 0, 8'h00);
      tbl[6]  = mk(0, 4'b1111, 32'h44332211,  0, 4'b0001, 0, 0, 0, 0, 8'h00);
      tbl[7]  = mk(0, 4'b1111, 32'h44332211,  0, 4'b0010, 1, 1, 0, 1, 8'h11);
      tbl[8]  = mk(0, 4'b1111, 32'h44332211,  0, 4'b0100, 2, 2, 1, 1, 8'h11);
      tbl[9]  = mk(0, 4'b1111, 32'h44332211,  0, 4'b1000, 3, 3, 2, 1, 8'h11);
      tbl[10] = mk(0, 4'b1111, 32'h44332211,  0, 4'b0001, 4, 4, 3, 1, 8'h11);
      tbl[11] = mk(0, 4'b1111, 32'h44332211,  0, 4'b0010, 5, 5, 0, 1, 8'h11);
      tbl[12] = mk(0, 4'b1111, 32'h44332211,  0, 4'b0100, 6, 6, 1, 1, 8'h11);
      tbl[13] = mk(0, 4'b1111, 32'h44332211,  0, 4'b1000, 7, 7, 2, 1, 8'h11);
      tbl[14] = mk(0, 4'b0000, 32'h0,         0, 4'b0000, 8, 8, 3, 1, 8'h11);

      // Reset state
      tick(); tick();
      chk("rst_empty", mem_empty, 1);
      chk("rst_full", mem_full, 0);
      chk("rst_count", count, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_uf", underflow_err, 0);

      // Table: single writer push/pop, then round-robin with all writers
      foreach (tbl[i]) begin
         rst_n = !tbl[i].rst; req_valid = tbl[i].valid; req_data = tbl[i].data;
         rd_en = tbl[i].rd; flush = 1'b0;
         #1;
         exp_d = '0;
         for (int j = 0; j < 4; j++) if (tbl[i].ready[j]) exp_d = tbl[i].data[j*8 +: 8];
         chk($sformatf("v%0d_ready", i), req_ready, tbl[i].ready);
         chk($sformatf("v%0d_mem_write", i), mem_write, |tbl[i].ready);
         chk($sformatf("v%0d_wdata", i), mem_data_write, exp_d);
         chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
         chk($sformatf("v%0d_wptr", i), mem_write_ptr, tbl[i].wptr);
         chk($sformatf("v%0d_gid", i), grant_id, tbl[i].gid);
         chk($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].rv);
         if (tbl[i].rv) chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd_data);
         tick();
      end
      rst_n = 1'b1;

      // Fill to full with writer 1 (8 stored already)
      for (int k = 0; k < 8; k++) begin
         req_valid = 4'b0010; req_data = {16'h0, 8'(8'h80 + k), 8'h0}; rd_en = 1'b0;
         #1;
         chk("fill_count", count, 5'(8 + k));
         chk("fill_af", almost_full, (8 + k) >= 12);
         chk("fill_full", mem_full, 0);
         chk("fill_ready", req_ready, 4'b0010);
         tick();
      end
      #1;
      chk("full_flag", mem_full, 1);
      chk("full_af", almost_full, 1);
      chk("full_count", count, 16);
      chk("full_ready", req_ready, 0);
      chk("full_mem_write", mem_write, 0);
      rd_en = 1'b1;
      #1;
      chk("fullpop_ready", req_ready, 0);
      chk("fullpop_rdata", rdata, 8'h11);
      tick();
      rd_en = 1'b0;
      #1;
      chk("afterpop_count", count, 15);
      chk("afterpop_full", mem_full, 0);
      chk("afterpop_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      #1;
      chk("refill_count", count, 16);
      chk("refill_full", mem_full, 1);

      // Underflow, then write-while-empty with a pop request
      do_reset();
      #1;
      chk("uf_clear", underflow_err, 0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      #1;
      chk("uf_set", underflow_err, 1);
      chk("uf_rptr", mem_read_ptr, 0);
      chk("uf_empty", mem_empty, 1);
      req_valid = 4'b0001; req_data = 32'h0000_005A; rd_en = 1'b1;
      #1;
      chk("wempty_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0; rd_en = 1'b0;
      #1;
      chk("wempty_count", count, 1);
      chk("wempty_rptr", mem_read_ptr, 0);
      chk("wempty_rdata", rdata, 8'h5A);

      // Streaming 40 words through writer 3 with pointer wrap
      q.push_back(8'h5A); wp = 5'd1; rp = 5'd0;
      for (int n = 0; n < 44; n++) begin
         req_valid = (n < 40) ? 4'b1000 : 4'b0000;
         req_data  = {8'(8'h20 + n), 24'h0};
         rd_en     = (q.size() > 0);
         #1;
         chk("st_count", count, 5'(q.size()));
         chk("st_empty", mem_empty, q.size() == 0);
         chk("st_full", mem_full, 0);
         chk("st_wptr", mem_write_ptr, wp);
         chk("st_rptr", mem_read_ptr, rp);
         if (n < 40) chk("st_ready", req_ready, 4'b1000);
         if (rd_en) begin
            chk("st_rdata", rdata, q[0]);
            void'(q.pop_front());
            rp = rp + 5'd1;
         end
         if (n < 40) begin
            q.push_back(8'(8'h20 + n));
            wp = wp + 5'd1;
         end
         tick();
      end
      req_valid = '0; rd_en = 1'b0;
      #1;
      chk("st_final_count", count, 0);
      chk("st_final_wptr", mem_write_ptr, 5'd9);
      chk("st_uf_sticky", underflow_err, 1);

      // Reset asserted mid-cycle with traffic
      req_valid = 4'b1111; req_data = 32'h44332211; rd_en = 1'b1;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mr_ready", req_ready, 0);
      chk("mr_mem_write", mem_write, 0);
      chk("mr_count", count, 0);
      chk("mr_empty", mem_empty, 1);
      chk("mr_gid", grant_id, 0);
      chk("mr_uf", underflow_err, 0);
      tick();
      req_valid = '0; rd_en = 1'b0; rst_n = 1'b1;

      // Flush with 5 words stored and writer 2 requesting
      for (int k = 0; k < 5; k++) begin
         req_valid = 4'b0001; req_data = {24'h0, 8'(8'h30 + k)};
         tick();
      end
      req_valid = 4'b0100; req_data = 32'h00C2_0000; flush = 1'b1;
      #1;
      chk("fl_ready", req_ready, 0);
      chk("fl_mem_write", mem_write, 0);
      chk("fl_count_before", count, 5);
      tick();
      flush = 1'b0;
      #1;
      chk("fl_count", count, 0);
      chk("fl_empty", mem_empty, 1);
      chk("fl_rptr", mem_read_ptr, 5);
      chk("fl_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      #1;
      chk("fl_post_count", count, 1);
      chk("fl_post_gid", grant_id, 2);
      chk("fl_post_rdata", rdata, 8'hC2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter_ctrl.md
Name: fifo_wr_arbiter_ctrl

Overview:
- Single-clock controller that shares one FIFO memory between NREQ writers and one reader.
- Round-robin arbitration grants at most one writer per cycle.
- Owns the write and read pointers; generates the memory write strobe, pointers, full/empty and count.
- Sits directly in front of the FIFO memory, which stores data on posedge when its write strobe is high and full is low, and reads combinationally at the read pointer.

Parameters:
- WIDTH, 8, data word width.
- PTR_WIDTH, 5, pointer width including the wrap bit; DEPTH = 2**(PTR_WIDTH-1) (16).
- NREQ, 4, number of writers; legal range 2..8.
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  writer i has a word.
- req_data  in  NREQ*WIDTH  writer i data in bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant; a word transfers when req_valid[i] & req_ready[i].
- grant_id  out  $clog2(NREQ)  index of the granted writer; holds its last value when there is no grant.
- flush  in  1  synchronous discard of all stored words.
- rd_en  in  1  consumer pop request.
- rd_valid  out  1  = !mem_empty; mem read data is valid.
- mem_write  out  1  memory write strobe.
- mem_write_ptr  out  PTR_WIDTH  write pointer to memory.
- mem_read_ptr  out  PTR_WIDTH  read pointer to memory.
- mem_data_write  out  WIDTH  muxed data of the granted writer.
- mem_full  out  1  FIFO full.
- mem_empty  out  1  FIFO empty.
- count  out  PTR_WIDTH  stored words, 0..DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- underflow_err  out  1  sticky; set by rd_en while empty.

Behaviour:
- Registered state: wr_ptr, rd_ptr, rr_ptr (highest-priority index), grant_id_q, underflow_err.
- Reset (async, rst_n=0) clears all state. Resulting outputs:
  - mem_empty=1, mem_full=0, count=0, almost_full=0 (AF_THRESH >= 1).
  - req_ready=0, mem_write=0, grant_id=0, underflow_err=0.
  - Memory contents are not cleared; the FIFO is logically empty.
- full = (wr_ptr[MSB] != rd_ptr[MSB]) && (lower bits equal). empty = (wr_ptr == rd_ptr).
- count = wr_ptr - rd_ptr, modulo 2**PTR_WIDTH.
- Flags are combinational from the registered pointers, so they update the cycle after a pointer change.
- Arbitration (combinational, same cycle):
  - If !full & !flush: scan req_valid from rr_ptr upward, wrapping modulo NREQ; the first set bit i is granted.
  - req_ready = one-hot(i); mem_write = 1; mem_data_write = req_data slice i.
  - No valid requester, full, or flush: req_ready=0, mem_write=0, mem_data_write=0.
  - req_ready does not depend on rd_en.
- On grant, at posedge: wr_ptr += 1 (wrapping through the MSB); rr_ptr <= (i+1) mod NREQ; grant_id_q <= i.
- Read:
  - When rd_en & !empty & !flush: rd_ptr += 1 at posedge.
  - Read data is show-ahead: the memory output at mem_read_ptr is the head word while rd_valid=1.
  - rd_en while empty: no pointer change; underflow_err <= 1. It stays set until reset.
- Simultaneous write and read:
  - Not full and not empty: both pointers advance; count is unchanged.
  - Full: write is blocked this cycle even if rd_en pops; the grant occurs the next cycle.
  - Empty: write is accepted and rd_en is ignored (underflow_err set); the word becomes readable the next cycle.
- flush=1 at posedge: rd_ptr <= wr_ptr; no grant and no pop that cycle; rr_ptr is unchanged. Next cycle empty=1, count=0.
- Wrap-around: after 2**PTR_WIDTH operations the pointers return to 0; the flag logic must hold across the MSB toggle.
- Reset mid-transfer: any in-flight grant is lost; no write strobe is produced while rst_n=0.

Test Plan:
- Reset, then single writer 0 pushes 0xA1, 0xA2 -> mem_write_ptr 0->1->2, count=2, rd_valid=1; two pops read 0xA1, 0xA2 in order; then empty=1, count=0.
- All 4 req_valid held high, 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3, each req_ready one-hot; after 8 words count=8.
- Fill 16 words -> full=1, almost_full=1 from count=12, req_ready=0 with valid high. Pop plus write in the same cycle while full -> write blocked; the grant appears the next cycle and count returns to 16.
- Write/read streaming of 40 words -> pointers wrap past 31->0, no false full/empty, data order preserved.
- Pop while empty -> rd_ptr unchanged, underflow_err=1, which persists through later traffic until rst_n=0.
- 5 words stored, flush=1 with req_valid[2]=1 -> no grant that cycle; next cycle count=0, empty=1; the following cycle writer 2 is granted. Assert rst_n low mid-stream -> all outputs at reset values immediately.
